seek_controller: RTL and testbench

- Parametrised successor to the floppy head-stepping controller.
- Issues STEP/DIR pulses with programmable step rate and pulse width from internal counters; no external step-rate clock.
- Supports relative, absolute and recalibrate seeks, a current-track register and a track-0 guard.
- Sits between the host register file and the FDD interface pins.

---
 rtl/seek_ctl_pkg.sv | 17 +
 rtl/step_timer.sv | 28 ++
 rtl/seek_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_seek_controller.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seek_ctl_pkg.sv
// Shared encodings for the floppy seek controller.
// Holds CMD_MODE codes and the seek state machine encoding.
package seek_ctl_pkg;

    localparam logic [1:0] MODE_REL   = 2'b00;
    localparam logic [1:0] MODE_ABS   = 2'b01;
    localparam logic [1:0] MODE_RECAL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PULSE,
        ST_GAP,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; expired is high while the count is zero.
// Ports: clk, reset (sync, high), load/value, enable, expired.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/seek_controller.sv
// Floppy head seek controller: relative/absolute/recalibrate seeks.
// Inputs: CLK, RESET, CMD_*, STEP_PERIOD, PULSE_WIDTH, SETTLE_TIME,
//   ABORT, TRACK0_IN. Outputs: STEP_OUT_n, DIR_OUT, BUSY, DONE, ERR,
//   TRACK0_HIT, CUR_TRACK, TRACK_VALID.
// Macro SEEK_SETTLE_EN: honour SETTLE_TIME after a seek that stepped.
module seek_controller
    import seek_ctl_pkg::*;
#(
    parameter int STEP_BITS = 8,
    parameter int RATE_BITS = 16,
    parameter int PW_BITS   = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_WRITE,
    input  logic [1:0]           CMD_MODE,
    input  logic                 CMD_DIR,
    input  logic [STEP_BITS-1:0] CMD_COUNT,
    input  logic [RATE_BITS-1:0] STEP_PERIOD,
    input  logic [PW_BITS-1:0]   PULSE_WIDTH,
    input  logic [RATE_BITS-1:0] SETTLE_TIME,
    input  logic                 ABORT,
    input  logic                 TRACK0_IN,
    output logic                 STEP_OUT_n,
    output logic                 DIR_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic                 TRACK0_HIT,
    output logic [STEP_BITS-1:0] CUR_TRACK,
    output logic                 TRACK_VALID
);

    localparam int XW = RATE_BITS + 2;

    state_t               state;
    logic [STEP_BITS-1:0] remaining;
    logic                 recal;
    logic                 stepped;
    logic [PW_BITS-1:0]   pw_q;
    logic [RATE_BITS-1:0] period_q;

    logic [PW_BITS-1:0]   pw_eff;
    logic [XW-1:0]        period_x;
    logic [XW-1:0]        pw_x;
    logic [RATE_BITS-1:0] pulse_load;
    logic [RATE_BITS-1:0] gap_load;

    logic                 t_load;
    logic [RATE_BITS-1:0] t_value;
    logic                 t_en;
    logic                 t_expired;
    logic                 s_load;
    logic [RATE_BITS-1:0] s_value;
    logic                 s_en;
    logic                 s_expired;

`ifdef SEEK_SETTLE_EN
    logic [RATE_BITS-1:0] settle_q;
`else
    // SETTLE_TIME is accepted but has no effect in this build.
    logic settle_unused;
    assign settle_unused = ^SETTLE_TIME;
`endif

    assign pw_eff   = (pw_q == '0) ? PW_BITS'(1) : pw_q;
    assign period_x = XW'(period_q);
    assign pw_x     = XW'(pw_eff);

    // Timer counts to zero, so load N-1 for an N-cycle interval.
    assign pulse_load = RATE_BITS'(pw_eff - PW_BITS'(1));

    // Fall-to-fall = pulse + gap + one CHECK cycle; gap is at least 1.
    assign gap_load =
        (period_x > pw_x + XW'(1)) ?
        RATE_BITS'(period_x - pw_x - XW'(2)) : '0;

    always_comb begin
        t_load  = 1'b0;
        t_value = pulse_load;
        if (state == ST_CHECK) begin
            t_load = 1'b1;
        end else if (state == ST_PULSE && t_expired) begin
            t_load  = 1'b1;
            t_value = gap_load;
        end
    end

    assign t_en   = (state == ST_PULSE) || (state == ST_GAP);
    assign s_load = (state == ST_CHECK);
    assign s_en   = (state == ST_SETTLE);

`ifdef SEEK_SETTLE_EN
    assign s_value = (stepped && settle_q != '0) ?
                     settle_q - RATE_BITS'(1) : '0;
`else
    assign s_value = '0;
`endif

    step_timer #(.W(RATE_BITS)) u_step_tmr (
        .clk     (CLK),
        .reset   (RESET),
        .load    (t_load),
        .value   (t_value),
        .enable  (t_en),
        .expired (t_expired)
    );

    step_timer #(.W(RATE_BITS)) u_settle_tmr (
        .clk     (CLK),
        .reset   (RESET),
        .load    (s_load),
        .value   (s_value),
        .enable  (s_en),
        .expired (s_expired)
    );

    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            STEP_OUT_n  <= 1'b1;
            DIR_OUT     <= 1'b1;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            TRACK0_HIT  <= 1'b0;
            CUR_TRACK   <= '0;
            TRACK_VALID <= 1'b0;
            remaining   <= '0;
            recal       <= 1'b0;
            stepped     <= 1'b0;
            pw_q        <= '0;
            period_q    <= '0;
`ifdef SEEK_SETTLE_EN
            settle_q    <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            if (state != ST_IDLE && ABORT) begin
                state      <= ST_IDLE;
                STEP_OUT_n <= 1'b1;
                DONE       <= 1'b1;
                ERR        <= 1'b1;
                // Half-issued step: head position is now unknown.
                if (state == ST_PULSE) begin
                    TRACK_VALID <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (CMD_WRITE && !ABORT) begin
                            ERR        <= 1'b0;
                            TRACK0_HIT <= 1'b0;
                            pw_q       <= PULSE_WIDTH;
                            period_q   <= STEP_PERIOD;
`ifdef SEEK_SETTLE_EN
                            settle_q   <= SETTLE_TIME;
`endif
                            stepped    <= 1'b0;
                            recal      <= (CMD_MODE == MODE_RECAL);
                            state      <= ST_CHECK;
                            case (CMD_MODE)
                                MODE_ABS: begin
                                    if (!TRACK_VALID) begin
                                        ERR       <= 1'b1;
                                        DONE      <= 1'b1;
                                        remaining <= '0;
                                        state     <= ST_IDLE;
                                    end else if (CMD_COUNT > CUR_TRACK) begin
                                        DIR_OUT   <= 1'b0;
                                        remaining <= CMD_COUNT - CUR_TRACK;
                                    end else if (CMD_COUNT < CUR_TRACK) begin
                                        DIR_OUT   <= 1'b1;
                                        remaining <= CUR_TRACK - CMD_COUNT;
                                    end else begin
                                        // Already there: inward so the
                                        // track-0 guard cannot fire.
                                        DIR_OUT   <= 1'b0;
                                        remaining <= '0;
                                    end
                                end
                                MODE_RECAL: begin
                                    DIR_OUT   <= 1'b1;
                                    remaining <= '1;
                                end
                                default: begin
                                    DIR_OUT   <= CMD_DIR;
                                    remaining <= CMD_COUNT;
                                end
                            endcase
                        end
                    end
                    ST_CHECK: begin
                        if (DIR_OUT && TRACK0_IN) begin
                            TRACK0_HIT  <= 1'b1;
                            CUR_TRACK   <= '0;
                            TRACK_VALID <= 1'b1;
                            state       <= ST_SETTLE;
                        end else if (remaining == '0) begin
                            // Recal ran out of steps without track 0.
                            if (recal) begin
                                ERR         <= 1'b1;
                                TRACK_VALID <= 1'b0;
                            end
                            state <= ST_SETTLE;
                        end else begin
                            STEP_OUT_n <= 1'b0;
                            stepped    <= 1'b1;
                            state      <= ST_PULSE;
                        end
                    end
                    ST_PULSE: begin
                        if (t_expired) begin
                            STEP_OUT_n <= 1'b1;
                            if (remaining != '0) begin
                                remaining <= remaining - STEP_BITS'(1);
                            end
                            if (DIR_OUT) begin
                                if (CUR_TRACK != '0) begin
                                    CUR_TRACK <= CUR_TRACK - STEP_BITS'(1);
                                end
                            end else if (CUR_TRACK != '1) begin
                                CUR_TRACK <= CUR_TRACK + STEP_BITS'(1);
                            end
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (t_expired) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_SETTLE: begin
                        if (s_expired) begin
                            DONE  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seek_controller.sv
// Self-checking bench for seek_controller: vector table, corner
// sequences and random commands against a behavioural drive model.
module tb_seek_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_WRITE = 1'b0;
    logic [1:0]  CMD_MODE = 2'b00;
    logic        CMD_DIR = 1'b0;
    logic [7:0]  CMD_COUNT = 8'd0;
    logic [15:0] STEP_PERIOD = 16'd0;
    logic [7:0]  PULSE_WIDTH = 8'd0;
    logic [15:0] SETTLE_TIME = 16'd0;
    logic        ABORT = 1'b0;
    logic        TRACK0_IN = 1'b0;
    logic        STEP_OUT_n;
    logic        DIR_OUT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        TRACK0_HIT;
    logic [7:0]  CUR_TRACK;
    logic        TRACK_VALID;

    seek_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_MODE    (CMD_MODE),
        .CMD_DIR     (CMD_DIR),
        .CMD_COUNT   (CMD_COUNT),
        .STEP_PERIOD (STEP_PERIOD),
        .PULSE_WIDTH (PULSE_WIDTH),
        .SETTLE_TIME (SETTLE_TIME),
        .ABORT       (ABORT),
        .TRACK0_IN   (TRACK0_IN),
        .STEP_OUT_n  (STEP_OUT_n),
        .DIR_OUT     (DIR_OUT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR),
        .TRACK0_HIT  (TRACK0_HIT),
        .CUR_TRACK   (CUR_TRACK),
        .TRACK_VALID (TRACK_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        int         count;
        int         pw;
        int         period;
        int         settle;
        int         exp_pulses;
        logic       exp_dir;
        int         exp_err;
        int         exp_hit;
        int         exp_cur;
        int         exp_valid;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    // Drive model: physical head track; TRACK0_IN follows it.
    int phys = 3;
    int m_cur = 0;
    int m_valid = 0;

    int r_pulses, r_bad_w, r_bad_iv, r_bad_dir;
    int r_done_c, r_rise_c, r_first_fall, r_abort_c, r_busy_done;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gap_cycles(input vec_t v);
        int w, g;
        w = (v.pw == 0) ? 1 : v.pw;
        g = v.period - w - 1;
        return (g < 1) ? 1 : g;
    endfunction

    function automatic int settle_cycles(input vec_t v);
`ifdef SEEK_SETTLE_EN
        return (v.settle > 0) ? v.settle : 1;
`else
        return 1 + 0 * v.settle;
`endif
    endfunction

    // Outcome of a command from the seek rules and the drive position.
    function automatic void predict(inout vec_t v);
        int rem, steps;
        logic d;
        v.exp_err = 0;
        v.exp_hit = 0;
        v.exp_cur = m_cur;
        v.exp_valid = m_valid;
        v.exp_pulses = 0;
        v.exp_dir = 1'b0;
        if (v.mode == 2'd1) begin
            if (m_valid == 0) begin
                v.exp_err = 1;
                return;
            end
            d = (v.count < m_cur);
            rem = d ? m_cur - v.count : v.count - m_cur;
        end else if (v.mode == 2'd2) begin
            d = 1'b1;
            rem = 255;
        end else begin
            d = v.dir;
            rem = v.count;
        end
        v.exp_dir = d;
        if (d) begin
            if (phys <= rem) begin
                steps = phys;
                v.exp_hit = 1;
                v.exp_cur = 0;
                v.exp_valid = 1;
            end else begin
                steps = rem;
                v.exp_cur = (m_cur > steps) ? m_cur - steps : 0;
                if (v.mode == 2'd2) begin
                    v.exp_err = 1;
                    v.exp_valid = 0;
                end
            end
        end else begin
            steps = rem;
            v.exp_cur = (m_cur + rem > 255) ? 255 : m_cur + rem;
        end
        v.exp_pulses = steps;
    endfunction

    task automatic run_cmd(input vec_t v, input int abort_fall);
        int   exp_w, exp_iv, last_fall, wcur;
        logic prev;
        exp_w = (v.pw == 0) ? 1 : v.pw;
        exp_iv = exp_w + gap_cycles(v) + 1;
        CMD_MODE = v.mode;
        CMD_DIR = v.dir;
        CMD_COUNT = 8'(v.count);
        PULSE_WIDTH = 8'(v.pw);
        STEP_PERIOD = 16'(v.period);
        SETTLE_TIME = 16'(v.settle);
        CMD_WRITE = 1'b1;
        @(posedge CLK); #1;
        CMD_WRITE = 1'b0;
        r_pulses = 0; r_bad_w = 0; r_bad_iv = 0; r_bad_dir = 0;
        r_done_c = -1; r_rise_c = -1; r_first_fall = -1;
        r_abort_c = -1; r_busy_done = -1;
        prev = 1'b1; wcur = 0; last_fall = -1;
        for (int c = 0; c < 6000; c++) begin
            if (prev && !STEP_OUT_n) begin
                r_pulses++;
                if (r_pulses == 1) r_first_fall = c;
                else if (c - last_fall != exp_iv) r_bad_iv++;
                if (DIR_OUT !== v.exp_dir) r_bad_dir++;
                last_fall = c;
                wcur = 0;
                if (r_pulses == abort_fall) begin
                    ABORT = 1'b1;
                    r_abort_c = c;
                end
            end
            if (!STEP_OUT_n) wcur++;
            if (!prev && STEP_OUT_n) begin
                if (r_abort_c < 0 && wcur != exp_w) r_bad_w++;
                r_rise_c = c;
                if (DIR_OUT) phys = (phys > 0) ? phys - 1 : 0;
                else phys = phys + 1;
                TRACK0_IN = (phys == 0);
            end
            prev = STEP_OUT_n;
            if (DONE) begin
                r_done_c = c;
                r_busy_done = BUSY;
                break;
            end
            @(posedge CLK); #1;
            ABORT = 1'b0;
        end
        chk("done_seen", (r_done_c >= 0) ? 1 : 0, 1);
    endtask

    task automatic check_vec(input vec_t v, input string t);
        int lat, exp_lat;
        chk({t, ".pulses"}, r_pulses, v.exp_pulses);
        chk({t, ".width_bad"}, r_bad_w, 0);
        chk({t, ".period_bad"}, r_bad_iv, 0);
        chk({t, ".dir_bad"}, r_bad_dir, 0);
        chk({t, ".busy_at_done"}, r_busy_done, 0);
        if (v.mode == 2'd1 && v.exp_err != 0) begin
            lat = r_done_c;
            exp_lat = 0;
        end else if (v.exp_pulses == 0) begin
            lat = r_done_c;
            exp_lat = 2;
        end else begin
            chk({t, ".first_fall"}, r_first_fall, 1);
            lat = r_done_c - r_rise_c;
            exp_lat = gap_cycles(v) + 1 + settle_cycles(v);
        end
        chk({t, ".done_latency"}, lat, exp_lat);
        @(posedge CLK); #1;
        chk({t, ".done_one_cycle"}, DONE, 0);
        chk({t, ".err"}, ERR, v.exp_err);
        chk({t, ".hit"}, TRACK0_HIT, v.exp_hit);
        chk({t, ".cur"}, CUR_TRACK, v.exp_cur);
        chk({t, ".valid"}, TRACK_VALID, v.exp_valid);
        m_cur = v.exp_cur;
        m_valid = v.exp_valid;
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".step_n"}, STEP_OUT_n, 1);
        chk({t, ".dir"}, DIR_OUT, 1);
        chk({t, ".busy"}, BUSY, 0);
        chk({t, ".done"}, DONE, 0);
        chk({t, ".err"}, ERR, 0);
        chk({t, ".hit"}, TRACK0_HIT, 0);
        chk({t, ".cur"}, CUR_TRACK, 0);
        chk({t, ".valid"}, TRACK_VALID, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   seen;

        // mode dir cnt pw per settle | pulses dir err hit cur valid
        tbl[0]  = '{2'd1, 1'b0, 5,  2, 6,  0,  0,  1'b0, 1, 0, 0,  0};
        tbl[1]  = '{2'd2, 1'b1, 0,  2, 6,  0,  3,  1'b1, 0, 1, 0,  1};
        tbl[2]  = '{2'd1, 1'b0, 10, 2, 8,  0,  10, 1'b0, 0, 0, 10, 1};
        tbl[3]  = '{2'd1, 1'b0, 4,  3, 9,  0,  6,  1'b1, 0, 0, 4,  1};
        tbl[4]  = '{2'd0, 1'b0, 3,  4, 20, 0,  3,  1'b0, 0, 0, 7,  1};
        tbl[5]  = '{2'd1, 1'b0, 7,  2, 6,  0,  0,  1'b0, 0, 0, 7,  1};
        tbl[6]  = '{2'd0, 1'b1, 8,  1, 3,  0,  7,  1'b1, 0, 1, 0,  1};
        tbl[7]  = '{2'd0, 1'b1, 8,  2, 6,  0,  0,  1'b1, 0, 1, 0,  1};
        tbl[8]  = '{2'd3, 1'b0, 2,  2, 2,  0,  2,  1'b0, 0, 0, 2,  1};
        tbl[9]  = '{2'd0, 1'b0, 1,  0, 0,  50, 1,  1'b0, 0, 0, 3,  1};
        tbl[10] = '{2'd0, 1'b1, 1,  5, 7,  0,  1,  1'b1, 0, 0, 2,  1};

        TRACK0_IN = (phys == 0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk_reset("reset");

        foreach (tbl[i]) begin
            run_cmd(tbl[i], 0);
            check_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort during the second step pulse.
        v = '{2'd0, 1'b0, 5, 3, 10, 0, 0, 1'b0, 0, 0, 0, 0};
        run_cmd(v, 2);
        chk("abort.pulses", r_pulses, 2);
        chk("abort.latency", r_done_c - r_abort_c, 1);
        chk("abort.step_n", STEP_OUT_n, 1);
        chk("abort.busy", r_busy_done, 0);
        chk("abort.err", ERR, 1);
        chk("abort.valid", TRACK_VALID, 0);
        chk("abort.cur", CUR_TRACK, 3);
        m_cur = 3;
        m_valid = 0;

        // Reset while waiting in the gap after the first step.
        CMD_MODE = 2'd0; CMD_DIR = 1'b0; CMD_COUNT = 8'd5;
        PULSE_WIDTH = 8'd3; STEP_PERIOD = 16'd10;
        CMD_WRITE = 1'b1;
        @(posedge CLK); #1;
        CMD_WRITE = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen < 2; c++) begin
            @(posedge CLK); #1;
            if (seen == 0 && !STEP_OUT_n) seen = 1;
            else if (seen == 1 && STEP_OUT_n) seen = 2;
        end
        chk("rstmid.saw_step", seen, 2);
        chk("rstmid.busy_before", BUSY, 1);
        phys = phys + 1;
        TRACK0_IN = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk_reset("rstmid");
        @(posedge CLK); #1;
        chk("rstmid.stays_idle", BUSY, 0);
        m_cur = 0;
        m_valid = 0;

        for (int n = 0; n < 40; n++) begin
            v.mode = 2'($urandom_range(0, 3));
            v.dir = (phys > 30) ? 1'b1 : 1'($urandom_range(0, 1));
            v.count = (v.mode == 2'd1) ? $urandom_range(0, 25)
                                       : $urandom_range(0, 10);
            v.pw = $urandom_range(0, 5);
            v.period = $urandom_range(0, 15);
            v.settle = $urandom_range(0, 6);
            predict(v);
            run_cmd(v, 0);
            check_vec(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
